// File: rtl/led_panel_scan_pkg.sv
// Shared types and constants for the LED panel scan controller.
// Pixel words are RGB444; geometry defaults describe a 64x64 panel scanned as two 32-row halves.
package led_panel_scan_pkg;

  localparam int DEF_COLS       = 64;
  localparam int DEF_ROWS       = 32;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_BITS       = 4;
  localparam int DEF_BASE_DELAY = 32;

  localparam int PIX_W = 12;
  localparam int R_HI  = 11;
  localparam int G_HI  = 7;
  localparam int B_HI  = 3;

  typedef enum logic [2:0] {
    SHIFT_ADDR,
    SHIFT_DATA,
    SHIFT_CLK,
    LATCH,
    DISPLAY,
    NEXT
  } scan_state_t;

endpackage

// File: rtl/led_panel_scan_bcm_oe_timer.sv
// Binary-code-modulation OE timer: once loaded, holds OE low for BASE_DELAY << plane cycles.
module bcm_oe_timer #(
  parameter int PLANE_W    = 2,
  parameter int CNT_W      = 9,
  parameter int BASE_DELAY = 32
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic [PLANE_W-1:0] i_plane,
  output logic               o_oe_n,
  output logic               o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  // Counts down to 1; the cycle showing 1 is the last lit cycle and raises done.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_load) begin
      r_cnt  <= CNT_W'(BASE_DELAY) << i_plane;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == CNT_W'(1)) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_done = r_busy && (r_cnt == CNT_W'(1));
  assign o_oe_n = ~r_busy;

endmodule

// File: rtl/led_panel_scan.sv
// Read-side scan controller: fetches pixel pairs, shifts one bit-plane per row pass into the
// panel, latches it and lights it for a binary-weighted time.
module led_panel_scan
  import led_panel_scan_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int ROWS       = DEF_ROWS,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BITS       = DEF_BITS,
  parameter int BASE_DELAY = DEF_BASE_DELAY
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic [ADDR_W-1:0]        o_mem_addr,
  output logic                     o_mem_rd,
  input  logic [2*PIX_W-1:0]       i_mem_rdata,
  output logic                     o_panel_r0,
  output logic                     o_panel_g0,
  output logic                     o_panel_b0,
  output logic                     o_panel_r1,
  output logic                     o_panel_g1,
  output logic                     o_panel_b1,
  output logic                     o_panel_clk,
  output logic                     o_panel_lat,
  output logic                     o_panel_oe_n,
  output logic [$clog2(ROWS)-1:0]  o_panel_row,
  output logic                     o_frame_start
);

  localparam int COL_W   = $clog2(COLS);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int PLANE_W = $clog2(BITS);
  localparam int CNT_W   = $clog2(BASE_DELAY << (BITS - 1)) + 1;

  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BITS - 1);

  scan_state_t r_state, w_next;

  logic               r_run;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [PLANE_W-1:0] r_plane;
  logic [ROW_W-1:0]   r_panel_row;
  logic               r_r0, r_g0, r_b0, r_r1, r_g1, r_b1;

  logic w_mem_rd, w_panel_clk, w_panel_lat, w_load, w_done, w_oe_n, w_frame_start;

  logic [PIX_W-1:0] w_upper, w_lower;

  assign w_upper = i_mem_rdata[2*PIX_W-1:PIX_W];
  assign w_lower = i_mem_rdata[PIX_W-1:0];

  // r_run stays low through reset so every strobe reads 0 until the first post-release edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run   <= 1'b0;
      r_state <= SHIFT_ADDR;
    end else begin
      r_run <= 1'b1;
      if (r_run) r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_mem_rd      = 1'b0;
    w_panel_clk   = 1'b0;
    w_panel_lat   = 1'b0;
    w_load        = 1'b0;
    w_frame_start = 1'b0;
    if (r_run) begin
      unique case (r_state)
        SHIFT_ADDR: begin
          w_mem_rd      = 1'b1;
          w_frame_start = (r_row == '0) && (r_plane == '0) && (r_col == '0);
          w_next        = SHIFT_DATA;
        end
        SHIFT_DATA: w_next = SHIFT_CLK;
        SHIFT_CLK: begin
          w_panel_clk = 1'b1;
          w_next      = (r_col == LAST_COL) ? LATCH : SHIFT_ADDR;
        end
        LATCH: begin
          w_panel_lat = 1'b1;
          w_load      = 1'b1;
          w_next      = DISPLAY;
        end
        DISPLAY: if (w_done) w_next = NEXT;
        NEXT:    w_next = SHIFT_ADDR;
        default: w_next = SHIFT_ADDR;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col   <= '0;
      r_row   <= '0;
      r_plane <= '0;
    end else if (r_run) begin
      if (r_state == SHIFT_CLK) r_col <= (r_col == LAST_COL) ? '0 : r_col + 1'b1;
      if (r_state == NEXT) begin
        if (r_plane == LAST_PLANE) begin
          r_plane <= '0;
          r_row   <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
        end else begin
          r_plane <= r_plane + 1'b1;
        end
      end
    end
  end

  // Colour bits are captured as SHIFT_DATA ends so they are steady for the whole panel_clk high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      {r_r0, r_g0, r_b0, r_r1, r_g1, r_b1} <= '0;
      r_panel_row <= '0;
    end else begin
      if (r_run && r_state == SHIFT_DATA) begin
        r_r0 <= w_upper[R_HI - r_plane_off()];
        r_g0 <= w_upper[G_HI - r_plane_off()];
        r_b0 <= w_upper[B_HI - r_plane_off()];
        r_r1 <= w_lower[R_HI - r_plane_off()];
        r_g1 <= w_lower[G_HI - r_plane_off()];
        r_b1 <= w_lower[B_HI - r_plane_off()];
      end
      if (r_run && r_state == LATCH) r_panel_row <= r_row;
    end
  end

  function automatic int r_plane_off();
    return (BITS - 1) - int'(r_plane);
  endfunction

  bcm_oe_timer #(
    .PLANE_W   (PLANE_W),
    .CNT_W     (CNT_W),
    .BASE_DELAY(BASE_DELAY)
  ) u_oe_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_load (w_load),
    .i_plane(r_plane),
    .o_oe_n (w_oe_n),
    .o_done (w_done)
  );

  assign o_mem_addr    = r_run ? ADDR_W'({r_row, r_col}) : '0;
  assign o_mem_rd      = w_mem_rd;
  assign o_frame_start = w_frame_start;
  assign o_panel_clk   = w_panel_clk;
  assign o_panel_lat   = w_panel_lat;
  assign o_panel_oe_n  = w_oe_n;
  assign o_panel_row   = r_panel_row;
  assign o_panel_r0    = r_r0;
  assign o_panel_g0    = r_g0;
  assign o_panel_b0    = r_b0;
  assign o_panel_r1    = r_r1;
  assign o_panel_g1    = r_g1;
  assign o_panel_b1    = r_b1;

endmodule

// File: tb/tb_led_panel_scan.sv
// Directed self-checking bench for led_panel_scan: reset values, colour/plane mapping,
// BCM timing, row wrap / frame period and an asynchronous mid-scan reset.
module tb_led_panel_scan;

  logic        clk;
  logic        rstN;
  logic [11:0] memAddr;
  logic        memRd;
  logic [23:0] memRdata;
  logic        r0, g0, b0, r1, g1, b1;
  logic        panelClk, panelLat, panelOeN;
  logic [4:0]  panelRow;
  logic        frameStart;

  logic [23:0] mem [0:4095];

  int assertCount = 0;
  int failCount   = 0;

  led_panel_scan dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .o_mem_addr   (memAddr),
    .o_mem_rd     (memRd),
    .i_mem_rdata  (memRdata),
    .o_panel_r0   (r0),
    .o_panel_g0   (g0),
    .o_panel_b0   (b0),
    .o_panel_r1   (r1),
    .o_panel_g1   (g1),
    .o_panel_b1   (b1),
    .o_panel_clk  (panelClk),
    .o_panel_lat  (panelLat),
    .o_panel_oe_n (panelOeN),
    .o_panel_row  (panelRow),
    .o_frame_start(frameStart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Image memory model: data appears on the edge that follows a read cycle and then holds.
  always @(posedge clk) begin
    if (memRd) memRdata <= mem[memAddr];
  end

  task automatic applyStimulus(input logic rstVal);
    rstN = rstVal;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_addr"}, 32'(memAddr), 32'd0);
    checkOutput({tag, "_rd"}, 32'(memRd), 32'd0);
    checkOutput({tag, "_colours"}, 32'({r0, g0, b0, r1, g1, b1}), 32'd0);
    checkOutput({tag, "_clk_lat"}, 32'({panelClk, panelLat}), 32'd0);
    checkOutput({tag, "_oe_n"}, 32'(panelOeN), 32'd1);
    checkOutput({tag, "_row"}, 32'(panelRow), 32'd0);
    checkOutput({tag, "_frame_start"}, 32'(frameStart), 32'd0);
  endtask

  int  cycle, secondFs, fsCount;
  int  dispIdx, planeIdx, rowIdx, colIdx;
  int  clkPulses, latCount, lowCount;
  logic prevOeN;
  logic found;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 24'h000000;
    mem[5]  = 24'hF00_00F;
    mem[6]  = 24'h800_000;
    mem[64] = 24'h0F0_0F0;
    memRdata = 24'h0;

    applyStimulus(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");

    applyStimulus(1'b1);
    @(negedge clk);
    checkOutput("first_addr", 32'(memAddr), 32'd0);
    checkOutput("first_rd", 32'(memRd), 32'd1);
    checkOutput("first_frame_start", 32'(frameStart), 32'd1);

    // Walk one full frame plus the first display of the next, following the scan in a model.
    cycle = 0; secondFs = -1; fsCount = 0;
    dispIdx = 0; planeIdx = 0; rowIdx = 0; colIdx = 0;
    clkPulses = 0; latCount = 0; lowCount = 0;
    prevOeN = 1'b1;
    while (dispIdx < 129 && cycle < 42000) begin
      if (frameStart) begin
        fsCount++;
        if (cycle != 0 && secondFs < 0) secondFs = cycle;
      end
      if (panelClk) begin
        if (rowIdx == 0 && planeIdx == 0 && colIdx == 5)
          checkOutput("col5_rgb", 32'({r0, g0, b0, r1, g1, b1}), 32'b100_001);
        if (rowIdx == 0 && colIdx == 6)
          checkOutput($sformatf("plane%0d_r0", planeIdx), 32'(r0), (planeIdx == 3) ? 32'd1 : 32'd0);
        if (rowIdx == 1 && planeIdx == 0 && colIdx == 0)
          checkOutput("row1_col0_rgb", 32'({r0, g0, b0, r1, g1, b1}), 32'b010_010);
        colIdx++;
        clkPulses++;
      end
      if (panelLat) begin
        latCount++;
        if (dispIdx < 8) checkOutput($sformatf("clk_pulses_d%0d", dispIdx), 32'(clkPulses), 32'd64);
        clkPulses = 0;
        colIdx = 0;
      end
      if (!panelOeN) begin
        lowCount++;
      end else if (!prevOeN) begin
        if (dispIdx < 8) begin
          checkOutput($sformatf("oe_low_plane%0d", planeIdx), 32'(lowCount), 32'(32 << planeIdx));
          checkOutput($sformatf("lat_count_d%0d", dispIdx), 32'(latCount), 32'd1);
        end
        if (dispIdx % 4 == 0)
          checkOutput($sformatf("panel_row_d%0d", dispIdx), 32'(panelRow), 32'(rowIdx));
        lowCount = 0;
        latCount = 0;
        dispIdx++;
        planeIdx = (planeIdx + 1) % 4;
        if (planeIdx == 0) rowIdx = (rowIdx + 1) % 32;
      end
      prevOeN = panelOeN;
      @(negedge clk);
      cycle++;
    end
    checkOutput("frame_walk_done", 32'(dispIdx), 32'd129);
    checkOutput("frame_period", 32'(secondFs), 32'd40192);
    checkOutput("frame_start_count", 32'(fsCount), 32'd2);

    // Run on to row 7, column 30 and pull reset between clock edges.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      if (memRd && memAddr == 12'h1DE) found = 1'b1;
    end
    checkOutput("reach_row7_col30", 32'(found), 32'd1);
    #1;
    applyStimulus(1'b0);
    #1;
    checkResetOutputs("midreset");
    repeat (3) @(negedge clk);
    checkOutput("midreset_hold_oe_n", 32'(panelOeN), 32'd1);
    checkOutput("midreset_hold_rd", 32'(memRd), 32'd0);
    applyStimulus(1'b1);
    @(negedge clk);
    checkOutput("resume_addr", 32'(memAddr), 32'd0);
    checkOutput("resume_rd", 32'(memRd), 32'd1);
    checkOutput("resume_frame_start", 32'(frameStart), 32'd1);
    checkOutput("resume_row", 32'(panelRow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/led_panel_scan.md
# led_panel_scan

Read-side scan controller for the dual-half LED panel. It walks the two image banks in raster order and fetches one 24-bit word per column: upper-half pixel in [23:12], lower-half pixel in [11:0]. Each RGB444 pixel is reduced to one bit-plane, shifted into the HUB75-style panel, latched, and displayed with binary-code-modulated OE timing. It sits between the image memory's read port (rd/address/rdata) and the panel pins, opposite the PS/2-driven writer.

## Interface
- COLS, 64, columns per row
- ROWS, 32, row pairs (scan lines) per half
- ADDR_W, 12, memory address width
- BITS, 4, colour depth per channel
- BASE_DELAY, 32, OE-on cycles for bit-plane 0

Ports:
- clk  in  1  system clock (one clock, all logic on posedge)
- rst_n  in  1  asynchronous active-low reset
- mem_addr  out  ADDR_W  memory address
- mem_rd  out  1  memory read strobe
- mem_rdata  in  24  {pixel_upper, pixel_lower}; valid on the posedge following an mem_rd cycle
- panel_r0, panel_g0, panel_b0  out  1 each  upper-half colour bits
- panel_r1, panel_g1, panel_b1  out  1 each  lower-half colour bits
- panel_clk  out  1  shift clock
- panel_lat  out  1  latch strobe
- panel_oe_n  out  1  output enable, active low
- panel_row  out  5  row select A..E
- frame_start  out  1  one-cycle pulse at start of each frame

## Operation
- Pixel format: R = [11:8], G = [7:4], B = [3:0]. Plane b drives channel bit b.
- Address: mem_addr = {1'b0, row[4:0], col[5:0]}.
- Scan order: for row 0..ROWS-1, plane 0..BITS-1, col 0..COLS-1.
- FSM states:
  - SHIFT_ADDR: mem_addr = col, mem_rd = 1, panel_clk = 0.
  - SHIFT_DATA: colour registers load from mem_rdata bit b; panel_clk = 0.
  - SHIFT_CLK: panel_clk = 1. If col == COLS-1, go to LATCH; otherwise increment col and go to SHIFT_ADDR.
  - LATCH: panel_lat = 1, panel_oe_n = 1, panel_row <= row.
  - DISPLAY: panel_oe_n = 0 for exactly BASE_DELAY << b cycles.
  - NEXT: panel_oe_n = 1. Advance the plane; on the last plane, reset plane to 0 and advance row; on the last row, wrap row to 0. Then go to SHIFT_ADDR.
- frame_start pulses in SHIFT_ADDR when row = 0, plane = 0 and col = 0, including the first cycle after reset.
- panel_oe_n is high in every state except DISPLAY. This covers row changes, so row switching never shows ghosting.
- mem_rd is high only in SHIFT_ADDR.

## Timing
- Reset (asynchronous): all outputs 0 except panel_oe_n = 1. State = SHIFT_ADDR, row = plane = col = 0, DISPLAY counter = 0.
- Reset asserted mid-operation: outputs return to reset values immediately. The scan restarts at row 0, plane 0, col 0 on the first posedge after release.
- Memory latency: address and rd are presented in SHIFT_ADDR; data is sampled at the end of SHIFT_DATA.
- Colour outputs are stable for the whole SHIFT_CLK high phase.
- Column cost: 3 cycles. Plane period: 3·COLS + 2 + (BASE_DELAY << b).
  - Defaults: 226 cycles for plane 0, 450 cycles for plane 3.
- Row period (defaults): 4·194 + 32·15 = 1256 cycles.
- Frame period (defaults): 32 · 1256 = 40192 cycles.
- DISPLAY counter is ceil(log2(BASE_DELAY << (BITS-1))) + 1 bits wide. It loads in LATCH and counts down to 1.
- Writes to memory during a scan are not coordinated. Tearing is accepted.

## Structure
- Shared package holds:
  - the state enum;
  - pixel field constants (R_HI = 11, G_HI = 7, B_HI = 3);
  - the panel geometry defaults.
- One natural sub-module: bcm_oe_timer. It takes plane b and a load pulse, and drives panel_oe_n and a done signal.
- Everything else stays in led_panel_scan.

## Test plan
- Reset values: hold rst_n = 0 → all outputs 0, panel_oe_n = 1. After release, the first cycle has mem_addr = 0, mem_rd = 1, frame_start = 1.
- Colour mapping: bench memory returns 24'hF00_00F at col 5, row 0 → at the col 5 SHIFT_CLK of plane 0, r0 = 1, b1 = 1, all other colour bits 0.
- Plane selection: pixel 0x800 (upper) → r0 = 0 in planes 0..2 and r0 = 1 in plane 3.
- BCM timing: count panel_oe_n low cycles per plane → exactly 32, 64, 128, 256. Also check 64 panel_clk pulses and one panel_lat pulse between displays.
- Row wrap: run one full frame → panel_row steps 0..31 and wraps to 0, and frame_start pulses again exactly 40192 cycles after the first.
- Mid-shift reset: assert rst_n at row 7, col 30 → outputs go to reset values without waiting for a clock. After release, the scan resumes at mem_addr = 0, panel_row = 0.
